morra_arbitro: RTL and testbench
================================

Name: morra_arbitro

Overview:
- Match controller that sequences the MorraCinese FSMD through a best-of-N match between two players.
- Collects each player's move through a valid/ready handshake and issues paired moves to the game for one cycle.
- Samples the manche/partita result, keeps the match score, enforces a per-manche move timeout, and restarts the game (M_INIZIO pulse) between partite.
- Sits between the player input logic and the MorraCinese instance.

Parameters:
VITTORIE, 2, partite a player must win to take the match (2 = best of 3)
TIMEOUT, 15, cycles in ATTESA before a missing move forfeits the partita; 0 disables the timeout
CW, 4, width of the score counters

Ports:
clk  in  1  clock, all logic on rising edge
INIZIO  in  1  synchronous active-high reset
GO  in  1  start a match; sampled only in IDLE or FINE
P1_MOSSA  in  2  player 1 move
P1_VALID  in  1  player 1 move valid
P1_READY  out  1  controller accepts a player 1 move
P2_MOSSA  in  2  player 2 move
P2_VALID  in  1  player 2 move valid
P2_READY  out  1  controller accepts a player 2 move
M_INIZIO  out  1  to MorraCinese INIZIO
M_PRIMO  out  2  to MorraCinese PRIMO
M_SECONDO  out  2  to MorraCinese SECONDO
M_MANCHE  in  2  from MorraCinese MANCHE
M_PARTITA  in  2  from MorraCinese PARTITA
PUNTI_P1  out  CW  partite won by player 1
PUNTI_P2  out  CW  partite won by player 2
PAREGGI  out  CW  drawn partite
ULTIMA_MANCHE  out  2  last valid manche result
BUSY  out  1  match in progress
MATCH_FINE  out  1  high in FINE
VINCITORE  out  2  match winner: 01 = P1, 10 = P2, 00 = none

Behaviour:
- Encodings:
  - Moves: 00 none, 01 sasso, 10 carta, 11 forbice.
  - MANCHE: 00 invalid, 01 P1, 10 P2, 11 tie.
  - PARTITA: 00 running, 01 P1, 10 P2, 11 draw.
- Reset (INIZIO=1):
  - State = IDLE; all counters, ULTIMA_MANCHE, VINCITORE, BUSY, MATCH_FINE, READYs and held moves = 0.
  - M_PRIMO = M_SECONDO = 00.
  - M_INIZIO = 1 combinationally while INIZIO=1, so the game is reset with the controller.
  - Reset mid-match aborts the match; no partial score is kept.
- IDLE:
  - BUSY=0.
  - GO -> AVVIO; score counters and VINCITORE cleared on the same edge.
- AVVIO (1 cycle):
  - M_INIZIO=1, M_PRIMO = M_SECONDO = 00, BUSY=1.
  - Held moves and timeout counter cleared.
  - -> ATTESA.
- ATTESA:
  - Px_READY=1 while player x has no held move.
  - A move is accepted when Px_VALID & Px_READY & Px_MOSSA != 00. The move 00 is ignored and READY stays high.
  - When both moves are held, go to GIOCA on the next edge.
  - Both players may be accepted in the same cycle.
  - Timeout counter increments each ATTESA cycle.
  - At count == TIMEOUT (TIMEOUT > 0):
    - Exactly one move held: the other player forfeits; the holder's PUNTI increments; -> check match.
    - Neither move held: counter restarts, no forfeit.
- GIOCA (1 cycle):
  - M_PRIMO = held P1 move, M_SECONDO = held P2 move, M_INIZIO=0.
  - -> ESITO.
  - Outside GIOCA, M_PRIMO/M_SECONDO = 00.
- ESITO (1 cycle):
  - Samples M_MANCHE/M_PARTITA (game result latency is 1 cycle after GIOCA).
  - If M_MANCHE != 00, ULTIMA_MANCHE is updated.
  - M_PARTITA = 00: clear held moves and timeout counter; -> ATTESA.
  - M_PARTITA = 01 / 10: corresponding PUNTI increments; -> check match.
  - M_PARTITA = 11: PAREGGI increments; -> AVVIO.
- Check match (same edge as the increment):
  - The incremented PUNTI reaching VITTORIE -> FINE; VINCITORE set.
  - Otherwise -> AVVIO.
- FINE:
  - MATCH_FINE=1, BUSY=0.
  - Score held.
  - GO -> AVVIO with counters cleared.
- Counters saturate at 2^CW-1.
- GO while BUSY is ignored.
- Simultaneous GO and INIZIO: reset wins.

Decomposition:
- Package morra_pkg:
  - Move, manche and partita encoding constants.
  - State enum {IDLE, AVVIO, ATTESA, GIOCA, ESITO, FINE}.
- One natural sub-module, morra_presa: per-player move-capture register with the READY/accept logic, instantiated twice.
- FSM, timeout counter and score counters stay in the top module.

Test Plan:
- Reset + GO:
  - Stimulus: INIZIO=1 for 2 cycles, then GO=1.
  - Required: M_INIZIO=1 during reset and for exactly one AVVIO cycle; BUSY=1; P1_READY = P2_READY = 1.
- Handshake:
  - Stimulus: P1 sends 10 at cycle 0, P2 sends 01 at cycle 3.
  - Required: one GIOCA cycle with M_PRIMO=10, M_SECONDO=01. Stub returns MANCHE=01, PARTITA=00 -> ULTIMA_MANCHE=01, controller back in ATTESA with both READY=1.
- Best-of-3 (VITTORIE=2):
  - Stimulus: stub returns PARTITA 01, 10, 01.
  - Required: PUNTI_P1=2, PUNTI_P2=1, MATCH_FINE=1, VINCITORE=01, three AVVIO pulses.
- Timeout (TIMEOUT=15):
  - Stimulus: only P2 sends 11; P1 stays idle.
  - Required: on the 15th ATTESA cycle PUNTI_P2 increments, no GIOCA cycle occurs, next state AVVIO.
- Draw and invalid move:
  - Stimulus: stub returns PARTITA=11; a later P1_VALID carries move 00.
  - Required: PAREGGI=1 with no PUNTI change; the 00 move is not accepted and P1_READY stays 1.
- Mid-match reset:
  - Stimulus: INIZIO=1 during GIOCA with PUNTI_P1=1.
  - Required: next cycle IDLE, all outputs 0, GO required to restart.

Source files
------------

// File: rtl/morra_pkg.sv
// Shared encodings and controller state type for the MorraCinese match controller.
package morra_pkg;

    // Player moves
    localparam logic [1:0] MOSSA_NULLA   = 2'b00;
    localparam logic [1:0] MOSSA_SASSO   = 2'b01;
    localparam logic [1:0] MOSSA_CARTA   = 2'b10;
    localparam logic [1:0] MOSSA_FORBICE = 2'b11;

    // Manche result reported by the game
    localparam logic [1:0] MANCHE_NULLA  = 2'b00;
    localparam logic [1:0] MANCHE_P1     = 2'b01;
    localparam logic [1:0] MANCHE_P2     = 2'b10;
    localparam logic [1:0] MANCHE_PARI   = 2'b11;

    // Partita result reported by the game
    localparam logic [1:0] PARTITA_CORSO = 2'b00;
    localparam logic [1:0] PARTITA_P1    = 2'b01;
    localparam logic [1:0] PARTITA_P2    = 2'b10;
    localparam logic [1:0] PARTITA_PARI  = 2'b11;

    // Match winner
    localparam logic [1:0] VINC_NESSUNO  = 2'b00;
    localparam logic [1:0] VINC_P1       = 2'b01;
    localparam logic [1:0] VINC_P2       = 2'b10;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        AVVIO  = 3'd1,
        ATTESA = 3'd2,
        GIOCA  = 3'd3,
        ESITO  = 3'd4,
        FINE   = 3'd5
    } stato_t;

endpackage

// File: rtl/morra_presa.sv
// Per-player move capture: READY while no move is held, latches the first non-null valid move.
module morra_presa
    import morra_pkg::*;
(
    input  logic       clk,
    input  logic       rst_i,
    input  logic       abil_i,
    input  logic       svuota_i,
    input  logic [1:0] mossa_i,
    input  logic       valid_i,
    output logic       ready_o,
    output logic       tenuta_o,
    output logic [1:0] mossa_o
);

    logic       tenuta_q;
    logic [1:0] mossa_q;
    logic       accetta;

    assign ready_o  = abil_i & ~tenuta_q;
    assign accetta  = valid_i & ready_o & (mossa_i != MOSSA_NULLA);
    assign tenuta_o = tenuta_q;
    assign mossa_o  = mossa_q;

    // Hold register: cleared between manches, loaded on an accepted handshake
    always_ff @(posedge clk) begin
        if (rst_i) begin
            tenuta_q <= 1'b0;
            mossa_q  <= MOSSA_NULLA;
        end else if (svuota_i) begin
            tenuta_q <= 1'b0;
            mossa_q  <= MOSSA_NULLA;
        end else if (accetta) begin
            tenuta_q <= 1'b1;
            mossa_q  <= mossa_i;
        end
    end

endmodule

// File: rtl/morra_arbitro.sv
// Match controller: sequences a best-of-N match of MorraCinese between two players.
module morra_arbitro
    import morra_pkg::*;
#(
    parameter int unsigned VITTORIE = 2,
    parameter int unsigned TIMEOUT  = 15,
    parameter int unsigned CW       = 4
) (
    input  logic          clk,
    input  logic          INIZIO,
    input  logic          GO,
    input  logic [1:0]    P1_MOSSA,
    input  logic          P1_VALID,
    output logic          P1_READY,
    input  logic [1:0]    P2_MOSSA,
    input  logic          P2_VALID,
    output logic          P2_READY,
    output logic          M_INIZIO,
    output logic [1:0]    M_PRIMO,
    output logic [1:0]    M_SECONDO,
    input  logic [1:0]    M_MANCHE,
    input  logic [1:0]    M_PARTITA,
    output logic [CW-1:0] PUNTI_P1,
    output logic [CW-1:0] PUNTI_P2,
    output logic [CW-1:0] PAREGGI,
    output logic [1:0]    ULTIMA_MANCHE,
    output logic          BUSY,
    output logic          MATCH_FINE,
    output logic [1:0]    VINCITORE
);

    localparam int unsigned TW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

    stato_t          stato_q, stato_d;
    logic [TW-1:0]   cnt_q, cnt_d;
    logic [CW-1:0]   p1_q, p1_d, p2_q, p2_d, par_q, par_d;
    logic [1:0]      ult_q, ult_d;
    logic [1:0]      vinc_q, vinc_d;
    logic            svuota, punto_p1, punto_p2;
    logic            tenuta1, tenuta2;
    logic [1:0]      mossa1, mossa2;
    logic            in_attesa;

    function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
        return (&v) ? v : v + CW'(1);
    endfunction

    assign in_attesa = (stato_q == ATTESA);

    morra_presa u_presa_p1 (
        .clk      (clk),
        .rst_i    (INIZIO),
        .abil_i   (in_attesa),
        .svuota_i (svuota),
        .mossa_i  (P1_MOSSA),
        .valid_i  (P1_VALID),
        .ready_o  (P1_READY),
        .tenuta_o (tenuta1),
        .mossa_o  (mossa1)
    );

    morra_presa u_presa_p2 (
        .clk      (clk),
        .rst_i    (INIZIO),
        .abil_i   (in_attesa),
        .svuota_i (svuota),
        .mossa_i  (P2_MOSSA),
        .valid_i  (P2_VALID),
        .ready_o  (P2_READY),
        .tenuta_o (tenuta2),
        .mossa_o  (mossa2)
    );

    // State, timeout and score registers
    always_ff @(posedge clk) begin
        if (INIZIO) begin
            stato_q <= IDLE;
            cnt_q   <= '0;
            p1_q    <= '0;
            p2_q    <= '0;
            par_q   <= '0;
            ult_q   <= MANCHE_NULLA;
            vinc_q  <= VINC_NESSUNO;
        end else begin
            stato_q <= stato_d;
            cnt_q   <= cnt_d;
            p1_q    <= p1_d;
            p2_q    <= p2_d;
            par_q   <= par_d;
            ult_q   <= ult_d;
            vinc_q  <= vinc_d;
        end
    end

    // Next state, timeout handling and score update with match-end check
    always_comb begin
        stato_d  = stato_q;
        cnt_d    = cnt_q;
        p1_d     = p1_q;
        p2_d     = p2_q;
        par_d    = par_q;
        ult_d    = ult_q;
        vinc_d   = vinc_q;
        svuota   = 1'b0;
        punto_p1 = 1'b0;
        punto_p2 = 1'b0;

        case (stato_q)
            IDLE, FINE: begin
                if (GO) begin
                    stato_d = AVVIO;
                    p1_d    = '0;
                    p2_d    = '0;
                    par_d   = '0;
                    vinc_d  = VINC_NESSUNO;
                end
            end
            AVVIO: begin
                svuota  = 1'b1;
                cnt_d   = '0;
                stato_d = ATTESA;
            end
            ATTESA: begin
                if (tenuta1 && tenuta2) begin
                    stato_d = GIOCA;
                end else begin
                    cnt_d = cnt_q + TW'(1);
                    if ((TIMEOUT != 0) && (cnt_d == TW'(TIMEOUT))) begin
                        // A lone held move wins the partita; nobody held just rearms the count
                        if (tenuta1 ^ tenuta2) begin
                            punto_p1 = tenuta1;
                            punto_p2 = tenuta2;
                        end else begin
                            cnt_d = '0;
                        end
                    end
                end
            end
            GIOCA: begin
                stato_d = ESITO;
            end
            ESITO: begin
                if (M_MANCHE != MANCHE_NULLA) begin
                    ult_d = M_MANCHE;
                end
                case (M_PARTITA)
                    PARTITA_CORSO: begin
                        svuota  = 1'b1;
                        cnt_d   = '0;
                        stato_d = ATTESA;
                    end
                    PARTITA_P1: punto_p1 = 1'b1;
                    PARTITA_P2: punto_p2 = 1'b1;
                    default: begin
                        par_d   = sat_inc(par_q);
                        stato_d = AVVIO;
                    end
                endcase
            end
            default: stato_d = IDLE;
        endcase

        if (punto_p1) begin
            p1_d = sat_inc(p1_q);
            if (p1_d == CW'(VITTORIE)) begin
                stato_d = FINE;
                vinc_d  = VINC_P1;
            end else begin
                stato_d = AVVIO;
            end
        end else if (punto_p2) begin
            p2_d = sat_inc(p2_q);
            if (p2_d == CW'(VITTORIE)) begin
                stato_d = FINE;
                vinc_d  = VINC_P2;
            end else begin
                stato_d = AVVIO;
            end
        end
    end

    // Game-side and status outputs decoded from the state register
    assign M_INIZIO      = INIZIO | (stato_q == AVVIO);
    assign M_PRIMO       = (stato_q == GIOCA) ? mossa1 : MOSSA_NULLA;
    assign M_SECONDO     = (stato_q == GIOCA) ? mossa2 : MOSSA_NULLA;
    assign BUSY          = (stato_q == AVVIO) || (stato_q == ATTESA) ||
                           (stato_q == GIOCA) || (stato_q == ESITO);
    assign MATCH_FINE    = (stato_q == FINE);
    assign PUNTI_P1      = p1_q;
    assign PUNTI_P2      = p2_q;
    assign PAREGGI       = par_q;
    assign ULTIMA_MANCHE = ult_q;
    assign VINCITORE     = vinc_q;

endmodule

// File: tb/tb_morra_arbitro.sv
// Bench for morra_arbitro: reference match model, game stub and per-cycle output checker.
module tb_morra_arbitro;

    localparam int VITT = 2;
    localparam int TOUT = 15;
    localparam int CWB  = 4;
    localparam int SMAX = (1 << CWB) - 1;

    logic           clk;
    logic           INIZIO, GO;
    logic [1:0]     P1_MOSSA, P2_MOSSA;
    logic           P1_VALID, P2_VALID, P1_READY, P2_READY;
    logic           M_INIZIO;
    logic [1:0]     M_PRIMO, M_SECONDO;
    logic [1:0]     mm_q, mp_q;
    logic [CWB-1:0] PUNTI_P1, PUNTI_P2, PAREGGI;
    logic [1:0]     ULTIMA_MANCHE, VINCITORE;
    logic           BUSY, MATCH_FINE;

    morra_arbitro #(.VITTORIE(VITT), .TIMEOUT(TOUT), .CW(CWB)) dut (
        .clk           (clk),
        .INIZIO        (INIZIO),
        .GO            (GO),
        .P1_MOSSA      (P1_MOSSA),
        .P1_VALID      (P1_VALID),
        .P1_READY      (P1_READY),
        .P2_MOSSA      (P2_MOSSA),
        .P2_VALID      (P2_VALID),
        .P2_READY      (P2_READY),
        .M_INIZIO      (M_INIZIO),
        .M_PRIMO       (M_PRIMO),
        .M_SECONDO     (M_SECONDO),
        .M_MANCHE      (mm_q),
        .M_PARTITA     (mp_q),
        .PUNTI_P1      (PUNTI_P1),
        .PUNTI_P2      (PUNTI_P2),
        .PAREGGI       (PAREGGI),
        .ULTIMA_MANCHE (ULTIMA_MANCHE),
        .BUSY          (BUSY),
        .MATCH_FINE    (MATCH_FINE),
        .VINCITORE     (VINCITORE)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    bit chk_en = 1'b0;
    int n_avvio = 0;
    int n_gioca = 0;

    function automatic void chk(input string nm, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %0d, want %0d", nm, $time, act, exp);
        end
    endfunction

    // Game stub: result appears the cycle after the moves are presented
    logic [1:0] nxt_mm, nxt_mp;
    always @(posedge clk) begin
        if (M_PRIMO != 2'b00) begin
            mm_q <= nxt_mm;
            mp_q <= nxt_mp;
        end else begin
            mm_q <= 2'b00;
            mp_q <= 2'b00;
        end
    end

    // Reference model of the match
    localparam int PH_OFF = 0, PH_START = 1, PH_WAIT = 2, PH_PLAY = 3, PH_RES = 4, PH_DONE = 5;
    int         ph = PH_OFF;
    bit         h1 = 1'b0, h2 = 1'b0;
    logic [1:0] mv1 = 2'b00, mv2 = 2'b00;
    int         wc = 0, s1 = 0, s2 = 0, dr = 0;
    logic [1:0] last = 2'b00, win = 2'b00;

    function automatic void award(input int p);
        int s;
        if (p == 1) begin
            s1 = (s1 < SMAX) ? s1 + 1 : s1;
            s  = s1;
        end else begin
            s2 = (s2 < SMAX) ? s2 + 1 : s2;
            s  = s2;
        end
        if (s == VITT) begin
            ph  = PH_DONE;
            win = 2'(p);
        end else begin
            ph = PH_START;
        end
    endfunction

    always @(posedge clk) begin : modello
        bit a1, a2;
        a1 = !h1 && P1_VALID && (P1_MOSSA != 2'b00);
        a2 = !h2 && P2_VALID && (P2_MOSSA != 2'b00);
        if (INIZIO) begin
            ph = PH_OFF; h1 = 0; h2 = 0; mv1 = 0; mv2 = 0; wc = 0;
            s1 = 0; s2 = 0; dr = 0; last = 0; win = 0;
        end else begin
            case (ph)
                PH_OFF, PH_DONE: if (GO) begin
                    ph = PH_START; s1 = 0; s2 = 0; dr = 0; win = 0;
                end
                PH_START: begin
                    h1 = 0; h2 = 0; wc = 0; ph = PH_WAIT;
                end
                PH_WAIT: begin
                    if (h1 && h2) ph = PH_PLAY;
                    else begin
                        wc++;
                        if (TOUT != 0 && wc == TOUT) begin
                            if (h1 != h2) award(h1 ? 1 : 2);
                            else wc = 0;
                        end
                    end
                    if (a1) begin h1 = 1; mv1 = P1_MOSSA; end
                    if (a2) begin h2 = 1; mv2 = P2_MOSSA; end
                end
                PH_PLAY: ph = PH_RES;
                PH_RES: begin
                    if (mm_q != 2'b00) last = mm_q;
                    case (int'(mp_q))
                        0: begin h1 = 0; h2 = 0; wc = 0; ph = PH_WAIT; end
                        1: award(1);
                        2: award(2);
                        default: begin dr = (dr < SMAX) ? dr + 1 : dr; ph = PH_START; end
                    endcase
                end
                default: ph = PH_OFF;
            endcase
        end
    end

    // Per-cycle comparison against the model, on the falling edge
    always @(negedge clk) begin
        if (chk_en) begin
            chk("M_INIZIO",  int'(M_INIZIO),  int'(INIZIO || ph == PH_START));
            chk("P1_READY",  int'(P1_READY),  int'(ph == PH_WAIT && !h1));
            chk("P2_READY",  int'(P2_READY),  int'(ph == PH_WAIT && !h2));
            chk("M_PRIMO",   int'(M_PRIMO),   (ph == PH_PLAY) ? int'(mv1) : 0);
            chk("M_SECONDO", int'(M_SECONDO), (ph == PH_PLAY) ? int'(mv2) : 0);
            chk("PUNTI_P1",  int'(PUNTI_P1),  s1);
            chk("PUNTI_P2",  int'(PUNTI_P2),  s2);
            chk("PAREGGI",   int'(PAREGGI),   dr);
            chk("ULTIMA",    int'(ULTIMA_MANCHE), int'(last));
            chk("BUSY",      int'(BUSY),      int'(ph >= PH_START && ph <= PH_RES));
            chk("MATCH_FINE", int'(MATCH_FINE), int'(ph == PH_DONE));
            chk("VINCITORE", int'(VINCITORE), int'(win));
        end
        if (M_INIZIO && !INIZIO) n_avvio++;
        if (M_PRIMO != 2'b00) n_gioca++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present moves until the game sees them (bounded)
    task automatic wait_gioca(input string nm);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 40 && !ok; i++) begin
            tick();
            if (M_PRIMO != 2'b00) ok = 1'b1;
        end
        chk(nm, int'(ok), 1);
    endtask

    task automatic play(input logic [1:0] a, input logic [1:0] b,
                        input logic [1:0] mm, input logic [1:0] mp);
        nxt_mm = mm; nxt_mp = mp;
        P1_MOSSA = a; P2_MOSSA = b;
        P1_VALID = 1'b1; P2_VALID = 1'b1;
        wait_gioca("play_gioca");
        P1_VALID = 1'b0; P2_VALID = 1'b0;
        tick();
        tick();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got running, want done");
        $fatal(1);
    end

    initial begin
        INIZIO = 1'b1; GO = 1'b0;
        P1_MOSSA = 2'b00; P2_MOSSA = 2'b00; P1_VALID = 1'b0; P2_VALID = 1'b0;
        nxt_mm = 2'b00; nxt_mp = 2'b00;

        // Reset for two cycles, then start
        tick();
        chk_en = 1'b1;
        chk("rst_m_inizio", int'(M_INIZIO), 1);
        chk("rst_busy", int'(BUSY), 0);
        tick();
        INIZIO = 1'b0; GO = 1'b1;
        n_avvio = 0;
        n_gioca = 0;
        tick();
        GO = 1'b0;
        chk("avvio_m_inizio", int'(M_INIZIO), 1);
        chk("avvio_busy", int'(BUSY), 1);
        tick();
        chk("attesa_m_inizio", int'(M_INIZIO), 0);
        chk("attesa_ready1", int'(P1_READY), 1);
        chk("attesa_ready2", int'(P2_READY), 1);

        // Handshake: P1 now, P2 three cycles later; manche to P1, partita continues
        nxt_mm = 2'b01; nxt_mp = 2'b00;
        P1_MOSSA = 2'b10; P1_VALID = 1'b1;
        tick();
        P1_VALID = 1'b0;
        chk("hs_ready1_low", int'(P1_READY), 0);
        tick();
        tick();
        P2_MOSSA = 2'b01; P2_VALID = 1'b1;
        tick();
        P2_VALID = 1'b0;
        tick();
        chk("hs_primo", int'(M_PRIMO), 2);
        chk("hs_secondo", int'(M_SECONDO), 1);
        tick();
        tick();
        chk("hs_ultima", int'(ULTIMA_MANCHE), 1);
        chk("hs_ready1_back", int'(P1_READY), 1);
        chk("hs_ready2_back", int'(P2_READY), 1);

        // Best of three: P1, P2, P1
        play(2'b10, 2'b01, 2'b01, 2'b01);
        play(2'b01, 2'b10, 2'b10, 2'b10);
        play(2'b11, 2'b10, 2'b01, 2'b01);
        chk("bo3_p1", int'(PUNTI_P1), 2);
        chk("bo3_p2", int'(PUNTI_P2), 1);
        chk("bo3_fine", int'(MATCH_FINE), 1);
        chk("bo3_vinc", int'(VINCITORE), 1);
        chk("bo3_avvio", n_avvio, 3);
        chk("bo3_busy", int'(BUSY), 0);

        // Timeout: only P2 moves, P1 forfeits on the 15th waiting cycle
        GO = 1'b1;
        tick();
        GO = 1'b0;
        n_gioca = 0;
        P2_MOSSA = 2'b11; P2_VALID = 1'b1;
        tick();
        repeat (14) tick();
        chk("to_before", int'(PUNTI_P2), 0);
        chk("to_cleared_p1", int'(PUNTI_P1), 0);
        tick();
        P2_VALID = 1'b0;
        chk("to_after", int'(PUNTI_P2), 1);
        chk("to_avvio", int'(M_INIZIO), 1);
        chk("to_no_gioca", n_gioca, 0);

        // Nobody moves: the count rearms without a forfeit
        repeat (20) tick();
        chk("idle_p1", int'(PUNTI_P1), 0);
        chk("idle_p2", int'(PUNTI_P2), 1);

        // Drawn partita
        play(2'b01, 2'b01, 2'b11, 2'b11);
        chk("draw_par", int'(PAREGGI), 1);
        chk("draw_p1", int'(PUNTI_P1), 0);
        chk("draw_p2", int'(PUNTI_P2), 1);
        chk("draw_ultima", int'(ULTIMA_MANCHE), 3);

        // Null move is never accepted; GO while busy is ignored
        tick();
        P1_MOSSA = 2'b00; P1_VALID = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("null_ready", int'(P1_READY), 1);
        end
        P1_VALID = 1'b0;
        GO = 1'b1;
        tick();
        GO = 1'b0;
        chk("go_busy", int'(BUSY), 1);
        chk("go_busy_par", int'(PAREGGI), 1);

        // Reset during GIOCA with a point already scored
        play(2'b10, 2'b01, 2'b01, 2'b01);
        chk("mid_p1", int'(PUNTI_P1), 1);
        nxt_mm = 2'b01; nxt_mp = 2'b01;
        P1_MOSSA = 2'b01; P2_MOSSA = 2'b11; P1_VALID = 1'b1; P2_VALID = 1'b1;
        wait_gioca("mid_gioca");
        P1_VALID = 1'b0; P2_VALID = 1'b0;
        INIZIO = 1'b1;
        tick();
        chk("mid_busy", int'(BUSY), 0);
        chk("mid_p1_clr", int'(PUNTI_P1), 0);
        chk("mid_p2_clr", int'(PUNTI_P2), 0);
        chk("mid_primo", int'(M_PRIMO), 0);
        INIZIO = 1'b0;
        tick();
        chk("mid_m_inizio", int'(M_INIZIO), 0);
        tick();
        chk("mid_idle", int'(BUSY), 0);

        // GO together with reset: reset wins
        INIZIO = 1'b1; GO = 1'b1;
        tick();
        INIZIO = 1'b0; GO = 1'b0;
        tick();
        chk("go_rst_busy", int'(BUSY), 0);
        GO = 1'b1;
        tick();
        GO = 1'b0;
        chk("restart_busy", int'(BUSY), 1);
        tick();
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
